// File: rtl/proc_pkg.sv
// Shared types for the processor run controller: run-state encoding and default counter width.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_HOLD = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/proc_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter import proc_pkg::*; #(
    parameter int W = DEF_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for processor cores: reset hold, execution window, stop on timeout or zero flag.
module proc_run_ctrl import proc_pkg::*; #(
    parameter int NUM_CORES  = 1,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 7,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       stop_on_zero,
    input  logic [NUM_CORES-1:0]       core_mask,
    input  logic [NUM_CORES-1:0]       zero,
    output logic [NUM_CORES-1:0]       core_reset,
    output logic [NUM_CORES-1:0]       core_en,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [NUM_CORES*CNT_W-1:0] zero_count,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    state_t               r_state;
    logic [HOLD_W-1:0]    r_hold;
    logic [CNT_W-1:0]     r_cycle;
    logic [NUM_CORES-1:0] r_core_reset;
    logic [NUM_CORES-1:0] r_core_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout;

    logic [NUM_CORES-1:0] w_zero_hit;
    logic                 w_zero_stop;
    logic                 w_last;
    logic                 w_clr;
    logic                 w_run;

    assign w_zero_hit  = zero & core_mask;
    assign w_zero_stop = stop_on_zero && (|w_zero_hit);
    assign w_last      = (r_cycle == CNT_W'(MAX_CYCLES - 1));
    assign w_clr       = start && !abort && ((r_state == IDLE) || (r_state == DONE));
    // abort freezes the counters on the cycle it is seen
    assign w_run       = (r_state == RUN) && !abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_cycle      <= '0;
            r_core_reset <= '1;
            r_core_en    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (abort) begin
            r_state      <= IDLE;
            r_core_reset <= '1;
            r_core_en    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state      <= RST_HOLD;
                        r_hold       <= HOLD_W'(RST_CYCLES);
                        r_cycle      <= '0;
                        r_timeout    <= 1'b0;
                        r_core_reset <= '1;
                        r_core_en    <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                RST_HOLD: begin
                    r_hold <= r_hold - 1'b1;
                    if (r_hold == HOLD_W'(1)) begin
                        r_state      <= RUN;
                        r_core_reset <= ~core_mask;
                        r_core_en    <= core_mask;
                    end
                end
                RUN: begin
                    r_cycle <= r_cycle + 1'b1;
                    // zero stop takes precedence when it coincides with the last budget cycle
                    if (w_zero_stop || w_last) begin
                        r_state      <= DONE;
                        r_timeout    <= !w_zero_stop;
                        r_core_reset <= '0;
                        r_core_en    <= '0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_core_reset <= ~core_mask;
                        r_core_en    <= core_mask;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_zc
        sat_counter #(.W(CNT_W)) u_zc (
            .clock   (clock),
            .reset   (reset),
            .i_clr   (w_clr),
            .i_inc   (w_run && w_zero_hit[gi]),
            .o_count (zero_count[gi*CNT_W +: CNT_W])
        );
    end

    assign core_reset  = r_core_reset;
    assign core_en     = r_core_en;
    assign cycle_count = r_cycle;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;

endmodule
